// File: rtl/token_drain.sv
// Drains BURST_LEN tokens from a token FIFO, spacing dequeues by GAP idle cycles.
// DEQ is combinational (earliest one cycle after START); an empty FIFO simply stalls the burst.
module token_drain #(
    parameter int CNT_WIDTH   = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EMPTY_N,
    output logic                 DEQ,
    input  logic                 START,
    input  logic [CNT_WIDTH-1:0] BURST_LEN,
    input  logic [3:0]           GAP,
    input  logic                 ABORT,
    input  logic                 CLR_COUNT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ABORTED,
    output logic                 STALLED,
    output logic [15:0]          COUNT
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] remaining;
    logic [3:0]           gap_cfg;
    logic [3:0]           gap_cnt;
    logic [7:0]           stall_cnt;
    logic [15:0]          count;
    logic                 done_q;
    logic                 aborted_q;
    logic                 done_nxt;
    logic                 aborted_nxt;
    logic                 deq;

    assign deq     = (state == ACTIVE) && EMPTY_N && (gap_cnt == 4'd0) && !ABORT && !RST;
    assign DEQ     = deq;
    assign BUSY    = (state == ACTIVE);
    assign DONE    = done_q;
    assign ABORTED = aborted_q;
    assign STALLED = (stall_cnt == STALL_MAX);
    assign COUNT   = count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    if (BURST_LEN != '0) begin
                        state_nxt = ACTIVE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (ABORT) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (deq && (remaining == CNT_WIDTH'(1))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining <= '0;
            gap_cfg   <= '0;
            gap_cnt   <= '0;
            stall_cnt <= '0;
            count     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= done_nxt;
            aborted_q <= aborted_nxt;

            if (state == IDLE) begin
                if (START && (BURST_LEN != '0)) begin
                    remaining <= BURST_LEN;
                    gap_cfg   <= GAP;
                    gap_cnt   <= 4'd0;
                end
            end else if (deq) begin
                remaining <= remaining - CNT_WIDTH'(1);
                gap_cnt   <= gap_cfg;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end

            // Starvation only accumulates while the burst stays active and no token moves.
            if ((state_nxt != ACTIVE) || deq) begin
                stall_cnt <= '0;
            end else if ((state == ACTIVE) && !EMPTY_N && (stall_cnt < STALL_MAX)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end

            if (CLR_COUNT) begin
                count <= deq ? 16'd1 : 16'd0;
            end else if (deq && (count != 16'hFFFF)) begin
                count <= count + 16'd1;
            end
        end
    end

    deq_without_token: assert property (@(posedge CLK) disable iff (RST) !(DEQ && !EMPTY_N))
        else $warning("token_drain: DEQ asserted while EMPTY_N is low");
    start_while_active: assert property (@(posedge CLK) disable iff (RST) !(START && (state == ACTIVE)))
        else $warning("token_drain: START ignored while a burst is active");

endmodule

// File: tb/tb_token_drain.sv
// Directed bench for token_drain: expected DEQ/DONE cycles are queued when a burst is
// launched and matched by a negedge monitor; levels are checked inline.
module tb_token_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        empty_n;
    logic        deq;
    logic        start;
    logic [7:0]  burst_len;
    logic [3:0]  gap;
    logic        abort_in;
    logic        clr_count;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        stalled;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit bulk   = 1'b0;
    int exp_deq[$];
    int exp_done_cyc[$];
    logic exp_done_ab[$];
    int e_cyc;
    logic e_ab;

    token_drain #(.CNT_WIDTH(8), .STALL_LIMIT(16)) dut (
        .CLK(clk), .RST(rst), .EMPTY_N(empty_n), .DEQ(deq), .START(start),
        .BURST_LEN(burst_len), .GAP(gap), .ABORT(abort_in), .CLR_COUNT(clr_count),
        .BUSY(busy), .DONE(done), .ABORTED(aborted), .STALLED(stalled), .COUNT(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard side: every DEQ / DONE the DUT produces must match the head of its queue.
    always @(negedge clk) begin
        if (deq) begin
            checks++;
            assert (empty_n === 1'b1) else begin
                errors++; $error("FAIL deq_while_empty cyc=%0d observed empty_n=%b expected 1", cyc, empty_n);
            end
        end
        if (deq && !bulk) begin
            checks++;
            assert (exp_deq.size() != 0) else begin
                errors++; $error("FAIL deq_unexpected cyc=%0d observed deq=1 expected 0", cyc);
            end
            if (exp_deq.size() != 0) begin
                e_cyc = exp_deq.pop_front();
                checks++;
                assert (cyc === e_cyc) else begin
                    errors++; $error("FAIL deq_cycle observed=%0d expected=%0d", cyc, e_cyc);
                end
            end
        end
        if (done && !bulk) begin
            checks++;
            assert (exp_done_cyc.size() != 0) else begin
                errors++; $error("FAIL done_unexpected cyc=%0d observed done=1 expected 0", cyc);
            end
            if (exp_done_cyc.size() != 0) begin
                e_cyc = exp_done_cyc.pop_front();
                e_ab  = exp_done_ab.pop_front();
                checks += 2;
                assert (cyc === e_cyc) else begin
                    errors++; $error("FAIL done_cycle observed=%0d expected=%0d", cyc, e_cyc);
                end
                assert (aborted === e_ab) else begin
                    errors++; $error("FAIL done_aborted cyc=%0d observed=%b expected=%b", cyc, aborted, e_ab);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++; $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [7:0] len, input logic [3:0] g);
        start     = 1'b1;
        burst_len = len;
        gap       = g;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic push_done(input int c, input logic ab);
        exp_done_cyc.push_back(c);
        exp_done_ab.push_back(ab);
    endtask

    initial begin
        int t;
        rst = 1'b1; empty_n = 1'b1; start = 1'b0; burst_len = '0; gap = '0;
        abort_in = 1'b0; clr_count = 1'b0;
        tick(2);
        chk("deq_in_reset", {31'd0, deq}, 32'd0);
        rst = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_aborted", {31'd0, aborted}, 32'd0);
        chk("reset_stalled", {31'd0, stalled}, 32'd0);
        chk("reset_count", {16'd0, count}, 32'd0);

        // Back-to-back drain, GAP 0
        t = cyc;
        for (int i = 1; i <= 4; i++) exp_deq.push_back(t + i);
        push_done(t + 5, 1'b0);
        start_burst(8'd4, 4'd0);
        chk("b2b_busy_t1", {31'd0, busy}, 32'd1);
        tick(5);
        chk("b2b_count", {16'd0, count}, 32'd4);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // Paced drain, GAP 2
        t = cyc;
        exp_deq.push_back(t + 1); exp_deq.push_back(t + 4); exp_deq.push_back(t + 7);
        push_done(t + 8, 1'b0);
        start_burst(8'd3, 4'd2);
        tick(8);
        chk("paced_count", {16'd0, count}, 32'd7);

        // Starvation: 20 cycles with the FIFO empty
        t = cyc;
        empty_n = 1'b0;
        start_burst(8'd2, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("stalled_k%0d", k), {31'd0, stalled}, (k >= 17) ? 32'd1 : 32'd0);
            tick(1);
        end
        chk("stalled_before_deq", {31'd0, stalled}, 32'd1);
        empty_n = 1'b1;
        exp_deq.push_back(t + 21); exp_deq.push_back(t + 22);
        push_done(t + 23, 1'b0);
        tick(1);
        chk("stalled_cleared", {31'd0, stalled}, 32'd0);
        tick(2);
        chk("starve_idle", {31'd0, busy}, 32'd0);
        chk("starve_count", {16'd0, count}, 32'd9);

        // Clear, then abort after one of five tokens
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        chk("clr_count", {16'd0, count}, 32'd0);
        t = cyc;
        exp_deq.push_back(t + 1);
        push_done(t + 3, 1'b1);
        start_burst(8'd5, 4'd0);
        tick(1);
        abort_in = 1'b1;
        #1;
        chk("abort_suppresses_deq", {31'd0, deq}, 32'd0);
        tick(1);
        abort_in = 1'b0;
        chk("abort_count", {16'd0, count}, 32'd1);
        tick(1);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        // Zero-length burst
        t = cyc;
        push_done(t + 1, 1'b0);
        start_burst(8'd0, 4'd0);
        chk("zero_len_busy", {31'd0, busy}, 32'd0);
        chk("zero_len_deq", {31'd0, deq}, 32'd0);
        tick(1);

        // Preset COUNT to 65533 with bulk bursts, then saturate
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        bulk = 1'b1;
        for (int b = 0; b < 256; b++) begin
            start_burst(8'd255, 4'd0);
            tick(255);
        end
        start_burst(8'd253, 4'd0);
        tick(253);
        tick(1);
        bulk = 1'b0;
        chk("preset_count", {16'd0, count}, 32'h0000FFFD);
        t = cyc;
        for (int i = 1; i <= 3; i++) exp_deq.push_back(t + i);
        push_done(t + 4, 1'b0);
        start_burst(8'd3, 4'd0);
        chk("sat_count_t1", {16'd0, count}, 32'h0000FFFD);
        tick(1);
        chk("sat_count_t2", {16'd0, count}, 32'h0000FFFE);
        tick(1);
        chk("sat_count_t3", {16'd0, count}, 32'h0000FFFF);
        tick(1);
        chk("sat_count_hold", {16'd0, count}, 32'h0000FFFF);
        tick(1);
        chk("sat_count_final", {16'd0, count}, 32'h0000FFFF);

        // Reset after two of six tokens
        t = cyc;
        exp_deq.push_back(t + 1); exp_deq.push_back(t + 2);
        start_burst(8'd6, 4'd0);
        tick(2);
        rst = 1'b1;
        #1;
        chk("deq_during_rst", {31'd0, deq}, 32'd0);
        tick(1);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_no_done", {31'd0, done}, 32'd0);
        tick(4);
        chk("rst_stays_idle", {31'd0, busy}, 32'd0);

        chk("deq_queue_drained", exp_deq.size(), 32'd0);
        chk("done_queue_drained", exp_done_cyc.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
